// File: rtl/ldpc_cn_sched.sv
`default_nettype none
// ============================================================================
// Module   : ldpc_cn_sched
// Brief    : Min-sum LDPC check-node scheduler (collect v2c, emit c2v in order).
//            Optional offset min-sum via `define LDPC_OFFSET_MS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ldpc_cn_sched #(
    parameter int DEG    = 8,
    parameter int OFFSET = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [7:0] in_data_i,
    input  logic       in_last_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [7:0] out_data_o,
    output logic       out_last_o,
    output logic       busy_o,
    output logic       err_o
);

    localparam int KW = $clog2(DEG);
    localparam logic [KW-1:0] C_KMAX   = KW'(DEG - 1);
    localparam logic [6:0]    C_MAGMAX = 7'h7F;

    typedef enum logic [0:0] {
        S_COLLECT = 1'b0,
        S_EMIT    = 1'b1
    } state_t;

    if (DEG < 2 || OFFSET < 0 || OFFSET > 127) begin : g_bad_param
        $error("ldpc_cn_sched: DEG must be >= 2 and OFFSET within 0..127");
    end

    state_t          state_q, state_d;
    logic [KW-1:0]   cnt_q, cnt_d;
    logic [KW-1:0]   nm1_q, nm1_d;
    logic [KW-1:0]   j_q, j_d;
    logic [KW-1:0]   idx_q, idx_d;
    logic [6:0]      min1_q, min1_d;
    logic [6:0]      min2_q, min2_d;
    logic            parity_q, parity_d;
    logic [DEG-1:0]  sign_q, sign_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_last_q, out_last_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;

    logic [6:0]      w_mag;
    logic [6:0]      w_sel_mag;
    logic [6:0]      w_emit_mag;
    logic            w_sgn;

    // -128 has no positive counterpart in 8 bits, so it saturates to 127.
    function automatic logic [6:0] sat_abs(input logic [7:0] x);
        logic [7:0] neg;
        neg = 8'd0 - x;
        if (x == 8'h80)
            return C_MAGMAX;
        else if (x[7])
            return neg[6:0];
        else
            return x[6:0];
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        nm1_d    = nm1_q;
        j_d      = j_q;
        idx_d    = idx_q;
        min1_d   = min1_q;
        min2_d   = min2_q;
        parity_d = parity_q;
        sign_d   = sign_q;
        err_d    = 1'b0;
        w_mag    = sat_abs(in_data_i);

        case (state_q)
            S_COLLECT: begin
                if (in_valid_i && in_ready_q) begin
                    sign_d[cnt_q] = in_data_i[7];
                    parity_d      = parity_q ^ in_data_i[7];
                    if (w_mag < min1_q) begin
                        min2_d = min1_q;
                        min1_d = w_mag;
                        idx_d  = cnt_q;
                    end else if (w_mag < min2_q) begin
                        min2_d = w_mag;
                    end
                    if (in_last_i || cnt_q == C_KMAX) begin
                        state_d = S_EMIT;
                        nm1_d   = cnt_q;
                        j_d     = '0;
                        cnt_d   = '0;
                        err_d   = ~in_last_i;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (out_valid_q && out_ready_i) begin
                    if (j_q == nm1_q) begin
                        state_d  = S_COLLECT;
                        cnt_d    = '0;
                        nm1_d    = '0;
                        j_d      = '0;
                        idx_d    = '0;
                        min1_d   = C_MAGMAX;
                        min2_d   = C_MAGMAX;
                        parity_d = 1'b0;
                        sign_d   = '0;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            default: state_d = S_COLLECT;
        endcase

        // Outputs are precomputed from next-state values so they are registered.
        w_sel_mag = (j_d == idx_d) ? min2_d : min1_d;
`ifdef LDPC_OFFSET_MS_EN
        w_emit_mag = (w_sel_mag > 7'(OFFSET)) ? (w_sel_mag - 7'(OFFSET)) : 7'd0;
`else
        w_emit_mag = w_sel_mag;
`endif
        w_sgn = parity_d ^ sign_d[j_d];

        in_ready_d  = (state_d == S_COLLECT);
        out_valid_d = (state_d == S_EMIT);
        out_last_d  = (state_d == S_EMIT) && (j_d == nm1_d);
        busy_d      = (state_d == S_EMIT) || (cnt_d != '0);
        if (state_d == S_EMIT)
            out_data_d = w_sgn ? (8'd0 - {1'b0, w_emit_mag}) : {1'b0, w_emit_mag};
        else
            out_data_d = 8'd0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_COLLECT;
            cnt_q       <= '0;
            nm1_q       <= '0;
            j_q         <= '0;
            idx_q       <= '0;
            min1_q      <= C_MAGMAX;
            min2_q      <= C_MAGMAX;
            parity_q    <= 1'b0;
            sign_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nm1_q       <= nm1_d;
            j_q         <= j_d;
            idx_q       <= idx_d;
            min1_q      <= min1_d;
            min2_q      <= min2_d;
            parity_q    <= parity_d;
            sign_q      <= sign_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;

endmodule
`default_nettype wire

// File: doc/ldpc_cn_sched.md
Name: ldpc_cn_sched

Overview:
- Check-node scheduler for min-sum LDPC decoding, built on the signed 8-bit LDPC primitives (saturating abs, min, sign handling).
- Collects one check node's variable-to-check (v2c) messages over a valid/ready stream, tracking min1, min2, the index of min1 and the sign parity.
- Then emits one check-to-variable (c2v) message per edge, in arrival order.
- Sits between the LDPC message buffer and the decoder's variable-node update.

Parameters:
- DEG, 8, maximum check-node degree; sizes the sign store and edge counter (at least 2).
- OFFSET, 1, offset subtracted from magnitudes; used only when LDPC_OFFSET_MS_EN is defined.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- in_valid_i  in  1  v2c message valid
- in_ready_o  out  1  scheduler accepts a v2c message
- in_data_i  in  8  signed v2c message (two's complement)
- in_last_i  in  1  final edge of the current check node
- out_valid_o  out  1  c2v message valid
- out_ready_i  in  1  consumer accepts the c2v message
- out_data_o  out  8  signed c2v message
- out_last_o  out  1  final c2v message of the check node
- busy_o  out  1  high in EMIT, or in COLLECT with at least one edge accepted
- err_o  out  1  one-cycle pulse: degree overflow (DEG edges accepted without in_last_i)

Behaviour:
- Reset values: state=COLLECT, in_ready_o=1, out_valid_o=0, out_data_o=0, out_last_o=0, busy_o=0, err_o=0. Counters are 0, min1=min2=127, parity=0.
- Reset is asynchronous and clears everything immediately, including mid-EMIT. The partial check node is discarded; there is no flush.
- Magnitude of x: x<0 gives -x, x>=0 gives x. -128 saturates to 127, so every magnitude is in 0..127.
- Sign of x is bit 7; zero counts as positive.

COLLECT state:
- in_ready_o=1.
- On each in_valid_i&&in_ready_o handshake at edge index k:
  - store sign[k]; parity ^= sign.
  - if mag < min1: min2 <= min1, min1 <= mag, idx <= k.
  - else if mag < min2: min2 <= mag.
  - Ties keep the first occurrence as min1; an equal later value becomes min2.
- Handshake with in_last_i=1, or handshake at k=DEG-1: the next state is EMIT, with edge count n=k+1.
- Overflow case (k=DEG-1 with in_last_i=0): err_o pulses for one cycle, in the cycle after the handshake.
- Degree 1: min2 stays 127.

EMIT state:
- in_ready_o=0.
- out_valid_o=1 starting the first cycle after entry, so last input to first output is 1 cycle.
- For output j: mag = (j==idx) ? min2 : min1; sgn = parity ^ sign[j]; out_data_o = sgn ? -mag : mag, so magnitude 0 gives 0.
- out_last_o = (j==n-1).
- Output j advances on each out_valid_o&&out_ready_i handshake.
- While out_ready_i=0, out_data_o and out_last_o hold stable.
- Handshake on the last output: the next state is COLLECT, with min1/min2/parity/counters reinitialised in the same edge. in_ready_o=1 on the next cycle.
- No overlap between check nodes. Throughput is one message per cycle in each phase.
- All arithmetic is 8-bit signed; no result leaves the -127..127 range.

Optional Feature:
- Macro: LDPC_OFFSET_MS_EN.
- Defined: offset min-sum. Emitted magnitude = max(mag - OFFSET, 0), computed at EMIT. min1/min2 selection and tie rules are unchanged.
- Undefined: plain min-sum. The OFFSET parameter is ignored and no subtractor is built.

Test Plan:
- Basic node: inputs 5,-3,7,-10 (last on -10), out_ready_i=1.
  - Internal: min1=3, idx=1, min2=5, parity=0.
  - Outputs: 3, -5, 3, -3; out_last_o on the 4th; in_ready_o returns 1 cycle later.
- Saturation: inputs -128, 20 (last).
  - Outputs: +20, then -127 (0x81); err_o stays 0.
- Ties/zero: inputs 4, 4, 0, -9 (last).
  - Internal: min1=0, idx=2, min2=4, parity=1.
  - Outputs: 0, 0, -4, 0.
- Overflow: DEG=8, eight inputs of 1 with no last.
  - err_o pulses once; eight outputs of 1 emitted; out_last_o on the 8th.
- Backpressure/reset: in the first test, hold out_ready_i=0 for 5 cycles at output 2 and check that 3 stays stable.
  - Then assert rst_i mid-EMIT: outputs clear immediately, in_ready_o=1 after release.
  - A new node 2,2 (last) then yields 2, 2.
- Offset (LDPC_OFFSET_MS_EN, OFFSET=1): inputs 5,-3,7,-10 → outputs 2, -4, 2, -2.
  - Input 1,-1 (last) → outputs 0, 0.
